// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants and types for the 12-bit-integer to 8-bit
//                float converter. Contains the field widths, the all-ones
//                field limits and the packed {sign, exp, mant} byte layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W  = 3;
    localparam int MANT_W = 4;
    localparam int FP_W   = 1 + EXP_W + MANT_W;

    localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
    localparam logic [MANT_W-1:0] MANT_MAX = '1;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_round_stage1.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_stage1
//  Description : Combinational round-half-up adder. Adds the round bit to the
//                truncated mantissa and returns a sum one bit wider so that
//                the caller can see the mantissa carry.
//  Ports       : i_mant  - truncated mantissa
//                i_xbit  - first discarded bit (round bit)
//                o_sum   - {carry, rounded mantissa}
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_stage1
    import fp_pkg::*;
#(
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic [MANT_W-1:0] i_mant,
    input  logic              i_xbit,
    output logic [MANT_W:0]   o_sum
);

    assign o_sum = {1'b0, i_mant} + {{MANT_W{1'b0}}, i_xbit};

endmodule : fp_round_stage1
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
//  Module      : fp_round_pack
//  Description : Final stage of the integer-to-float converter. Stage 1
//                rounds (round-half-up) and registers the result, stage 2
//                renormalises on mantissa carry, saturates at the largest
//                exponent and registers the packed {S,E,F} byte. Valid/ready
//                flow control, one transaction per clock, two in flight max.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                in_valid/in_ready    - upstream handshake
//                in_sign/exp/mant/xbit- fields from the normalise stage
//                out_valid/out_ready  - downstream handshake
//                fp_out               - packed {sign, exp, mant}
//                round_cnt, sat_cnt   - transfer statistics (optional)
//  Options     : FP_ROUND_PACK_STATS_EN adds round_cnt / sat_cnt outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int MANT_W = fp_pkg::MANT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic                    in_xbit,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   fp_out
`ifdef FP_ROUND_PACK_STATS_EN
    ,
    output logic [15:0]             round_cnt,
    output logic [15:0]             sat_cnt
`endif
);

    localparam logic [EXP_W-1:0]  C_EXP_MAX   = '1;
    localparam logic [MANT_W-1:0] C_MANT_MAX  = '1;
    localparam logic [MANT_W-1:0] C_MANT_MSB  = {1'b1, {(MANT_W-1){1'b0}}};
    localparam logic [EXP_W-1:0]  C_EXP_ONE   = {{(EXP_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                  r_rst_done;   // keeps in_ready low for one cycle after reset
    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic [EXP_W-1:0]      r_s1_exp;
    logic [MANT_W:0]       r_s1_sum;
    logic                  r_s2_valid;
    logic [EXP_W+MANT_W:0] r_fp_out;

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    logic                  w_in_ready;
    logic                  w_accept;
    logic [MANT_W:0]       w_sum;
    logic [EXP_W-1:0]      w_s2_exp;
    logic [MANT_W-1:0]     w_s2_mant;

`ifdef FP_ROUND_PACK_STATS_EN
    // Flags only exist when something downstream of stage 2 consumes them.
    logic                  r_s1_rnd;
    logic                  r_s2_rnd;
    logic                  r_s2_sat;
    logic                  w_s2_sat;
    logic [15:0]           r_round_cnt;
    logic [15:0]           r_sat_cnt;
`endif

    // ------------------------------------------------------------------------
    // Flow control: a stage may take new data when it is empty or its
    // contents move on this edge. in_ready therefore depends combinationally
    // on out_ready, which lets a full pipe drain and refill on the same edge.
    // ------------------------------------------------------------------------
    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_adv;
    assign w_in_ready = rst_n && r_rst_done && w_s1_adv;
    assign w_accept   = in_valid && w_in_ready;

    assign in_ready   = w_in_ready;
    assign out_valid  = r_s2_valid;
    assign fp_out     = r_fp_out;

    // ------------------------------------------------------------------------
    // Stage 1: round adder
    // ------------------------------------------------------------------------
    fp_round_stage1 #(
        .MANT_W (MANT_W)
    ) u_round (
        .i_mant (in_mant),
        .i_xbit (in_xbit),
        .o_sum  (w_sum)
    );

    // ------------------------------------------------------------------------
    // Stage 2: renormalise on carry, saturate when the exponent cannot grow.
    // A carry out of the mantissa means the rounded value is exactly 2^(e+1),
    // so the fraction becomes the hidden-one pattern 100..0.
    // ------------------------------------------------------------------------
    always_comb begin
        w_s2_exp  = r_s1_exp;
        w_s2_mant = r_s1_sum[MANT_W-1:0];
`ifdef FP_ROUND_PACK_STATS_EN
        w_s2_sat  = 1'b0;
`endif
        if (r_s1_sum[MANT_W]) begin
            if (r_s1_exp == C_EXP_MAX) begin
                w_s2_exp  = C_EXP_MAX;
                w_s2_mant = C_MANT_MAX;
`ifdef FP_ROUND_PACK_STATS_EN
                w_s2_sat  = 1'b1;
`endif
            end else begin
                w_s2_exp  = r_s1_exp + C_EXP_ONE;
                w_s2_mant = C_MANT_MSB;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rst_done <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_fp_out   <= '0;
        end else begin
            r_rst_done <= 1'b1;
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_sign <= in_sign;
                    r_s1_exp  <= in_exp;
                    r_s1_sum  <= w_sum;
                end
            end
            // fp_out only changes when stage 2 may advance, so it is held
            // while a result waits for out_ready.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_fp_out <= {r_s1_sign, w_s2_exp, w_s2_mant};
                end
            end
        end
    end

`ifdef FP_ROUND_PACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_rnd    <= 1'b0;
            r_s2_rnd    <= 1'b0;
            r_s2_sat    <= 1'b0;
            r_round_cnt <= '0;
            r_sat_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_rnd <= in_xbit;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_s2_rnd <= r_s1_rnd;
                r_s2_sat <= w_s2_sat;
            end
            // Counters wrap naturally at 16'hFFFF.
            if (r_s2_valid && out_ready) begin
                r_round_cnt <= r_round_cnt + {15'd0, r_s2_rnd};
                r_sat_cnt   <= r_sat_cnt + {15'd0, r_s2_sat};
            end
        end
    end

    assign round_cnt = r_round_cnt;
    assign sat_cnt   = r_sat_cnt;
`endif

endmodule : fp_round_pack
`default_nettype wire

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Final stage of the 12-bit-integer to 8-bit-float converter.
- Sits directly downstream of the leading-zero/normalise stage. Consumes its sign, 3-bit exponent, 4-bit mantissa and round (x) bit.
- Applies round-half-up with mantissa-carry renormalisation and saturation, then packs the {S,E,F} byte.
- Two-stage registered pipeline with valid/ready flow control; full throughput of one transaction per clock.

Parameters:
- EXP_W, 3, exponent field width.
- MANT_W, 4, mantissa field width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream has a transaction.
- in_ready  out  1  block accepts a transaction this cycle.
- in_sign  in  1  sign of original integer.
- in_exp  in  EXP_W  exponent from normalise stage.
- in_mant  in  MANT_W  truncated mantissa.
- in_xbit  in  1  first discarded bit (round bit).
- out_valid  out  1  fp_out holds a result.
- out_ready  in  1  downstream consumes when high with out_valid.
- fp_out  out  1+EXP_W+MANT_W  packed {sign, exp, mant}.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous, active-low: rst_n sampled on the clk rising edge.
  - Reset clears s1_valid, s2_valid, out_valid=0 and fp_out=0. in_ready becomes 1 one cycle after rst_n rises; it is held 0 while rst_n is low.
  - Reset mid-operation drops all in-flight transactions. No partial outputs are produced.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - Once out_valid is asserted, fp_out is held stable until the transfer.
- Pipeline, stage 1 (round):
  - s1 loads when in_valid && in_ready.
  - Computes sum = {0, in_mant} + in_xbit (MANT_W+1 bits).
  - Registers sign, exponent, sum, and flag rnd = in_xbit.
- Pipeline, stage 2 (renormalise / saturate / pack):
  - sum carry=0: E=exp, F=sum[MANT_W-1:0].
  - sum carry=1 and exp<max: E=exp+1, F=1000...0 (MSB set, rest 0).
  - sum carry=1 and exp==max (all ones): saturate to E=all ones, F=all ones; flag sat=1.
  - Sign passes through unchanged; zero input (exp=0, mant=0, x=0) packs to {sign,0,0}.
- Advance rules (no bubbles):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready).
- Latency and throughput:
  - Latency is exactly 2 cycles: accepted at edge N gives out_valid at edge N+2 if out_ready stays high.
  - Throughput 1/cycle.
- Full condition: both stages valid and out_ready=0 gives in_ready=0. Maximum two transactions buffered; order strictly preserved.
- Simultaneous consume and accept: on the same edge as a full pipeline drains, a new input is accepted; no dead cycle.

Optional Feature:
- Macro: FP_ROUND_PACK_STATS_EN.
- Defined: adds outputs round_cnt[15:0] and sat_cnt[15:0].
  - round_cnt increments when an output transfer carries rnd=1.
  - sat_cnt increments when an output transfer carries sat=1.
  - Both counters wrap at 16'hFFFF to 0 and are cleared by reset.
- Not defined: ports and counter logic absent; flags are not stored past stage 2.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MANT_W constants.
  - FP_W = 1+EXP_W+MANT_W.
  - EXP_MAX and MANT_MAX all-ones constants.
  - Packed struct/typedef for {sign, exp, mant}.
- Natural sub-module: fp_round_stage1, the combinational round adder, reused by any future format variant. The pipeline control stays in the top.

Test Plan:
- Basic rounding: sign=0, exp=3, mant=1010, x=1, out_ready=1 -> fp_out=0_011_1011 (0x3B) two cycles after acceptance.
- No round: sign=1, exp=5, mant=1100, x=0 -> 1_101_1100 (0xDC).
- Carry renormalise: exp=3, mant=1111, x=1 -> 0_100_1000 (0x48).
- Saturation: sign=1, exp=7, mant=1111, x=1 -> 0xFF; with stats enabled, sat_cnt=1 and round_cnt=1.
- Backpressure: stream 0x01..0x05 (exp=0, mant=value, x=0) with out_ready low cycles 2-6.
  - in_ready drops after two accepts.
  - Output order is 01,02,03,04,05 with no loss or duplication; fp_out stable while stalled.
- Reset mid-flight: two transactions in pipe, rst_n=0 for one edge -> out_valid=0, fp_out=0 next cycle; in_ready=1 the cycle after rst_n returns high; the old data never appears.
